kat_adc_sync_align: RTL and testbench
=====================================

KAT_ADC_SYNC_ALIGN -- requirements
Module: kat_adc_sync_align

Interface
REQ-001 SHALL have parameter PERIOD_BITS, default 24: width of the sync-period counter.
REQ-002 SHALL have parameter LOCK_COUNT, default 4: consecutive matching sync edges required to lock, range 1..15.
REQ-003 SHALL use one clock and an asynchronous, active-high reset: ctrl_clk_in and ctrl_reset; all logic is clocked on the rising edge of ctrl_clk_in.
REQ-004 ctrl_clk_in  in  1  ADC-interface read-side clock.
REQ-005 ctrl_reset  in  1  asynchronous active-high reset.
REQ-006 in_datai  in  32  I samples; lane0 (oldest) = [7:0], lane3 (newest) = [31:24].
REQ-007 in_dataq  in  32  Q samples, same lane order as in_datai.
REQ-008 in_sync  in  4  per-lane sync bits; bit k belongs to lane k.
REQ-009 in_valid  in  1  high = the input word is valid this cycle.
REQ-010 out_datai, out_dataq  out  32 each  realigned words; lane0 is the oldest sample.
REQ-011 out_sync  out  1  high with the output word whose lane0 is a sync rising-edge sample.
REQ-012 out_valid  out  1  output word valid.
REQ-013 phase  out  2  lane index of the most recent sync edge.
REQ-014 locked  out  1  high in state LOCKED.
REQ-015 sync_period  out  PERIOD_BITS  valid-word count between the last two edges.
REQ-016 err_count  out  16  count of lock losses, saturating.

Function
REQ-017 Edge detection SHALL evaluate only on cycles where in_valid=1, using the 5-bit vector {in_sync, last_sync}; last_sync is lane3 of the previous valid word.
- Edge at lane k when in_sync[k]=1 and the preceding lane bit is 0.
- When several edges occur in one word, the lowest k wins.
REQ-018 Cycles with in_valid=0 SHALL leave all state, counters, and held words unchanged, and SHALL force out_valid=0.
REQ-019 On an edge in word n, phase SHALL be set to k, registered at the clock edge that samples word n.
REQ-020 Aligner:
- When word n+1 is valid, the next output lanes 0..3 SHALL be lanes phase..3 of word n, followed by lanes 0..phase-1 of word n+1.
- phase=0 outputs word n unchanged.
REQ-021 Latency SHALL be fixed: out_valid rises one cycle after the in_valid cycle carrying word n+1, for every phase value.
REQ-022 out_sync SHALL be 1 on the output word built from word n if word n contained an edge, and 0 otherwise.
REQ-023 The period counter SHALL increment on each valid word without an edge, and saturate at all-ones.
- On an edge, sync_period takes counter+1 (saturating) and the counter clears.
REQ-024 The state machine SHALL have states SEARCH, ACQUIRE, and LOCKED. A match means: edge phase equals the stored phase, the new period equals the stored sync_period, and the period is not saturated.
- SEARCH: first edge -> ACQUIRE, match_cnt=0.
- ACQUIRE: match -> match_cnt+1; reaching LOCK_COUNT -> LOCKED. Mismatch -> match_cnt=0, remain in ACQUIRE.
- LOCKED: match -> stay. Mismatch -> ACQUIRE, match_cnt=0, err_count+1. The saturating counter reaching all-ones without an edge -> SEARCH, err_count+1.
REQ-025 err_count SHALL saturate at 16'hFFFF.
REQ-026 The first edge after reset SHALL only baseline phase and period; it SHALL never count as a match.

Reset
REQ-027 ctrl_reset SHALL asynchronously clear all outputs, held words, last_sync, counters, match_cnt, and err_count to 0, and put the state machine in SEARCH.
REQ-028 Reset asserted mid-word SHALL discard any partially aligned word; no out_valid SHALL occur until two valid words have arrived after deassertion.

Configuration
REQ-029 Macro KAT_SYNC_ALIGN_ERR_CNT_EN:
- When defined, err_count SHALL behave as in REQ-024 and REQ-025.
- When undefined, err_count SHALL be tied to 0, no counter flops SHALL exist, and all other behaviour SHALL be unchanged.

Verification
REQ-030 phase=0, sync every 16 words, LOCK_COUNT=4 -> out_sync each 16th output word, sync_period=16, locked rises on the 5th edge.
REQ-031 Edge at lane 2 -> out_datai lanes = {w(n+1)[1], w(n+1)[0], w(n)[3], w(n)[2]} (lane3..lane0), phase=2, out_sync=1.
REQ-032 Locked at period 16; one edge arrives at period 17 -> locked falls, err_count=1, and relock occurs after 4 further matches at period 17.
REQ-033 in_valid toggling 1,0,1,0 with sync period 8 valid words -> sync_period=8, latency constant, out_valid never high on an invalid-following cycle.
REQ-034 Reset pulse asserted two cycles into a locked stream -> all outputs 0 immediately, state SEARCH, first out_valid on the second valid word after release.
REQ-035 PERIOD_BITS=4 with no sync while LOCKED -> counter saturates at 15, state SEARCH, err_count+1; with the macro undefined -> err_count stays 0.

Source files
------------

// File: rtl/kat_adc_sync_align.sv
// kat_adc_sync_align: ADC sync-edge detector, lane realigner and lock tracker.
// Define KAT_SYNC_ALIGN_ERR_CNT_EN to build the saturating lock-loss counter (err_count).
module kat_adc_sync_align #(
  parameter int PERIOD_BITS = 24,
  parameter int LOCK_COUNT  = 4
) (
  input  logic                   ctrl_clk_in,
  input  logic                   ctrl_reset,
  input  logic [31:0]            in_datai,
  input  logic [31:0]            in_dataq,
  input  logic [3:0]             in_sync,
  input  logic                   in_valid,
  output logic [31:0]            out_datai,
  output logic [31:0]            out_dataq,
  output logic                   out_sync,
  output logic                   out_valid,
  output logic [1:0]             phase,
  output logic                   locked,
  output logic [PERIOD_BITS-1:0] sync_period,
  output logic [15:0]            err_count
);
  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;
  localparam logic [PERIOD_BITS-1:0] CNT_MAX = '1;
  localparam logic [3:0] LC = 4'(LOCK_COUNT);
  state_t                 state_q, state_d;
  logic [3:0]             match_q, match_d;
  logic [PERIOD_BITS-1:0] cnt_q, cnt_d, period_q, period_d, cnt_inc;
  logic [1:0]             phase_q, phase_d, k_edge;
  logic                   last_q, last_d, held_v_q, held_v_d, held_e_q, held_e_d;
  logic [31:0]            hi_q, hi_d, hq_q, hq_d, oi_q, oi_d, oq_q, oq_d;
  logic                   os_q, os_d, ov_q, ov_d, hit, match;
  logic [4:0]             sv;
  logic [63:0]            wide_i, wide_q;
  always_comb begin
    sv = {in_sync, last_q};
    hit = 1'b0;
    k_edge = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (sv[k+1] && !sv[k]) begin
        hit = 1'b1;
        k_edge = 2'(k);
      end
    end
    cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : PERIOD_BITS'(cnt_q + 1'b1);
    match = (k_edge == phase_q) && (cnt_inc == period_q) && (cnt_inc != CNT_MAX);
    // Lanes phase..3 of the held word followed by lanes 0..phase-1 of the new word.
    wide_i = {in_datai, hi_q} >> {phase_q, 3'b000};
    wide_q = {in_dataq, hq_q} >> {phase_q, 3'b000};
  end
  always_comb begin
    state_d = state_q;
    match_d = match_q;
    cnt_d = cnt_q;
    period_d = period_q;
    phase_d = phase_q;
    last_d = last_q;
    held_v_d = held_v_q;
    held_e_d = held_e_q;
    hi_d = hi_q;
    hq_d = hq_q;
    oi_d = oi_q;
    oq_d = oq_q;
    os_d = 1'b0;
    ov_d = 1'b0;
    if (in_valid) begin
      last_d = in_sync[3];
      hi_d = in_datai;
      hq_d = in_dataq;
      held_v_d = 1'b1;
      held_e_d = hit;
      ov_d = held_v_q;
      os_d = held_v_q && held_e_q;
      oi_d = held_v_q ? wide_i[31:0] : oi_q;
      oq_d = held_v_q ? wide_q[31:0] : oq_q;
      cnt_d = hit ? '0 : cnt_inc;
      phase_d = hit ? k_edge : phase_q;
      period_d = hit ? cnt_inc : period_q;
      if (hit) begin
        case (state_q)
          SEARCH: begin
            state_d = ACQUIRE;
            match_d = 4'd0;
          end
          ACQUIRE: begin
            match_d = match ? match_q + 4'd1 : 4'd0;
            state_d = (match && (match_q + 4'd1 == LC)) ? LOCKED : ACQUIRE;
          end
          LOCKED: begin
            state_d = match ? LOCKED : ACQUIRE;
            match_d = match ? match_q : 4'd0;
          end
          default: state_d = SEARCH;
        endcase
      end else if (state_q == LOCKED && cnt_inc == CNT_MAX && cnt_q != CNT_MAX) begin
        state_d = SEARCH;
        match_d = 4'd0;
      end
    end
  end
  always_ff @(posedge ctrl_clk_in or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      state_q <= SEARCH;
      match_q <= '0;
      cnt_q <= '0;
      period_q <= '0;
      phase_q <= '0;
      last_q <= 1'b0;
      held_v_q <= 1'b0;
      held_e_q <= 1'b0;
      hi_q <= '0;
      hq_q <= '0;
      oi_q <= '0;
      oq_q <= '0;
      os_q <= 1'b0;
      ov_q <= 1'b0;
    end else begin
      state_q <= state_d;
      match_q <= match_d;
      cnt_q <= cnt_d;
      period_q <= period_d;
      phase_q <= phase_d;
      last_q <= last_d;
      held_v_q <= held_v_d;
      held_e_q <= held_e_d;
      hi_q <= hi_d;
      hq_q <= hq_d;
      oi_q <= oi_d;
      oq_q <= oq_d;
      os_q <= os_d;
      ov_q <= ov_d;
    end
  end
`ifdef KAT_SYNC_ALIGN_ERR_CNT_EN
  logic [15:0] err_q, err_d;
  logic        loss;
  // A lock loss is either a mismatching edge or the period counter saturating while locked.
  assign loss = in_valid && state_q == LOCKED &&
                (hit ? !match : (cnt_inc == CNT_MAX && cnt_q != CNT_MAX));
  assign err_d = (loss && err_q != 16'hFFFF) ? err_q + 16'd1 : err_q;
  always_ff @(posedge ctrl_clk_in or posedge ctrl_reset) begin
    if (ctrl_reset) err_q <= '0;
    else err_q <= err_d;
  end
  assign err_count = err_q;
`else
  assign err_count = '0;
`endif
  assign out_datai = oi_q;
  assign out_dataq = oq_q;
  assign out_sync = os_q;
  assign out_valid = ov_q;
  assign phase = phase_q;
  assign locked = state_q == LOCKED;
  assign sync_period = period_q;
endmodule

// File: tb/tb_kat_adc_sync_align.sv
// tb_kat_adc_sync_align: directed checks of edge detection, realignment, locking and reset.
module tb_kat_adc_sync_align;
  logic clk = 1'b0, rst = 1'b1, v = 1'b0;
  logic [31:0] di = '0, dq = '0;
  logic [3:0] sy = '0;
  logic [31:0] o_i, o_q, o4_i, o4_q;
  logic o_s, o_v, lk, o4_s, o4_v, lk4;
  logic [1:0] ph, ph4;
  logic [23:0] sp;
  logic [3:0] sp4;
  logic [15:0] ec, ec4;
  int errs = 0, checks = 0;
`ifdef KAT_SYNC_ALIGN_ERR_CNT_EN
  localparam logic [15:0] E1 = 16'd1;
`else
  localparam logic [15:0] E1 = 16'd0;
`endif

  kat_adc_sync_align dut (
    .ctrl_clk_in(clk), .ctrl_reset(rst), .in_datai(di), .in_dataq(dq), .in_sync(sy), .in_valid(v),
    .out_datai(o_i), .out_dataq(o_q), .out_sync(o_s), .out_valid(o_v), .phase(ph), .locked(lk),
    .sync_period(sp), .err_count(ec));

  kat_adc_sync_align #(.PERIOD_BITS(4)) dut4 (
    .ctrl_clk_in(clk), .ctrl_reset(rst), .in_datai(di), .in_dataq(dq), .in_sync(sy), .in_valid(v),
    .out_datai(o4_i), .out_dataq(o4_q), .out_sync(o4_s), .out_valid(o4_v), .phase(ph4), .locked(lk4),
    .sync_period(sp4), .err_count(ec4));

  always #5 clk = ~clk;

  function automatic logic [31:0] wd(input int n);
    return {8'(n*4+3), 8'(n*4+2), 8'(n*4+1), 8'(n*4)};
  endfunction

  // Expected realigned word: the byte stream continues p lanes further into word n.
  function automatic logic [31:0] al(input int n, input int p);
    logic [31:0] r;
    for (int j = 0; j < 4; j++) r[j*8 +: 8] = 8'(n*4 + p + j);
    return r;
  endfunction

  task automatic step(input logic vv, input logic [3:0] s, input int n);
    v = vv;
    sy = s;
    di = wd(n);
    dq = wd(n) ^ 32'hA5A5A5A5;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    v = 1'b0;
    sy = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic stream(input int n, input int per, input logic [3:0] s);
    for (int w = 0; w < n; w++) step(1'b1, (w % per == per - 1) ? s : 4'b0000, w);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    v = 1'b1;
    sy = 4'hF;
    di = 32'hFFFFFFFF;
    dq = 32'hFFFFFFFF;
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({o_v, o_s, lk, ph} !== 5'b0) begin errs++; $display("FAIL reset_ctl got=%b exp=00000", {o_v, o_s, lk, ph}); end
    checks++; if ({o_i, o_q} !== 64'b0) begin errs++; $display("FAIL reset_data got=%h exp=0", {o_i, o_q}); end
    checks++; if (sp !== 24'd0 || ec !== 16'd0) begin errs++; $display("FAIL reset_cnt sp=%0d ec=%0d exp=0", sp, ec); end
    checks++; if ({o4_v, lk4, sp4, ec4} !== 22'b0) begin errs++; $display("FAIL reset_dut4 got=%h exp=0", {o4_v, lk4, sp4, ec4}); end
    rst = 1'b0;
  endtask

  task automatic test_lock_phase0();
    logic [31:0] ei;
    logic es;
    do_reset();
    for (int w = 0; w < 80; w++) begin
      step(1'b1, (w % 16 == 15) ? 4'b0001 : 4'b0000, w);
      if (w == 0) begin
        checks++; if (o_v !== 1'b0) begin errs++; $display("FAIL first_word_valid got=%b exp=0", o_v); end
      end else begin
        ei = wd(w - 1);
        es = ((w - 1) % 16 == 15);
        checks++;
        if ({o_v, o_s, o_i, o_q} !== {1'b1, es, ei, ei ^ 32'hA5A5A5A5}) begin
          errs++; $display("FAIL p0_word%0d got v=%b s=%b i=%h exp v=1 s=%b i=%h", w - 1, o_v, o_s, o_i, es, ei);
        end
      end
      if (w == 63) begin
        checks++; if (lk !== 1'b0) begin errs++; $display("FAIL lock_edge4 got=%b exp=0", lk); end
      end
    end
    checks++; if (lk !== 1'b1) begin errs++; $display("FAIL lock_edge5 got=%b exp=1", lk); end
    checks++; if (sp !== 24'd16 || ph !== 2'd0) begin errs++; $display("FAIL p0_period got=%0d ph=%0d exp=16 ph=0", sp, ph); end
  endtask

  task automatic test_period_change();
    for (int w = 80; w <= 164; w++) begin
      step(1'b1, ((w - 79) % 17 == 0) ? 4'b0001 : 4'b0000, w);
      if (w == 95) begin
        checks++; if (lk !== 1'b1) begin errs++; $display("FAIL still_locked got=%b exp=1", lk); end
      end
      if (w == 96) begin
        checks++; if (lk !== 1'b0) begin errs++; $display("FAIL unlock17 got=%b exp=0", lk); end
        checks++; if (ec !== E1) begin errs++; $display("FAIL err_on_mismatch got=%0d exp=%0d", ec, E1); end
        checks++; if (sp !== 24'd17) begin errs++; $display("FAIL period17 got=%0d exp=17", sp); end
      end
      if (w == 147) begin
        checks++; if (lk !== 1'b0) begin errs++; $display("FAIL relock_early got=%b exp=0", lk); end
      end
    end
    checks++; if (lk !== 1'b1) begin errs++; $display("FAIL relock17 got=%b exp=1", lk); end
    checks++; if (ec !== E1) begin errs++; $display("FAIL err_after_relock got=%0d exp=%0d", ec, E1); end
  endtask

  task automatic test_phases();
    for (int k = 0; k < 4; k++) begin
      do_reset();
      step(1'b1, 4'b0000, 0);
      step(1'b1, 4'(1 << k), 1);
      checks++; if (ph !== 2'(k)) begin errs++; $display("FAIL phase%0d got=%0d exp=%0d", k, ph, k); end
      checks++; if ({o_v, o_s, o_i} !== {2'b10, wd(0)}) begin errs++; $display("FAIL pre_edge%0d got v=%b s=%b i=%h exp v=1 s=0 i=%h", k, o_v, o_s, o_i, wd(0)); end
      step(1'b1, 4'b0000, 2);
      checks++;
      if ({o_v, o_s, o_i, o_q} !== {2'b11, al(1, k), al(1, k) ^ 32'hA5A5A5A5}) begin
        errs++; $display("FAIL align%0d got v=%b s=%b i=%h q=%h exp v=1 s=1 i=%h", k, o_v, o_s, o_i, o_q, al(1, k));
      end
    end
    do_reset();
    step(1'b1, 4'b1010, 0);
    checks++; if (ph !== 2'd1) begin errs++; $display("FAIL lowest_edge got=%0d exp=1", ph); end
    step(1'b1, 4'b1000, 1);
    checks++; if (ph !== 2'd3) begin errs++; $display("FAIL edge_lane3 got=%0d exp=3", ph); end
    step(1'b1, 4'b0001, 2);
    checks++; if (ph !== 2'd3 || o_s !== 1'b1) begin errs++; $display("FAIL last_sync_hold got ph=%0d s=%b exp ph=3 s=1", ph, o_s); end
    step(1'b1, 4'b0001, 3);
    checks++; if (ph !== 2'd0 || o_s !== 1'b0) begin errs++; $display("FAIL edge_lane0 got ph=%0d s=%b exp ph=0 s=0", ph, o_s); end
  endtask

  task automatic test_valid_toggle();
    int c;
    do_reset();
    for (int i = 0; i < 64; i++) begin
      if (i % 2 == 1) begin
        step(1'b0, 4'hF, 999);
        checks++; if (o_v !== 1'b0) begin errs++; $display("FAIL gap_valid%0d got=%b exp=0", i, o_v); end
      end else begin
        c = i / 2;
        step(1'b1, (c % 8 == 7) ? 4'b0001 : 4'b0000, c);
        if (c >= 1) begin
          checks++;
          if ({o_v, o_s, o_i} !== {1'b1, ((c - 1) % 8 == 7), wd(c - 1)}) begin
            errs++; $display("FAIL tog_word%0d got v=%b s=%b i=%h exp v=1 i=%h", c - 1, o_v, o_s, o_i, wd(c - 1));
          end
        end
      end
    end
    checks++; if (sp !== 24'd8) begin errs++; $display("FAIL tog_period got=%0d exp=8", sp); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    stream(80, 16, 4'b0010);
    step(1'b1, 4'b0000, 80);
    step(1'b1, 4'b0000, 81);
    checks++; if ({lk, o_v, ph} !== 4'b1101) begin errs++; $display("FAIL pre_reset got=%b exp=1101", {lk, o_v, ph}); end
    #3;
    rst = 1'b1;
    v = 1'b0;
    #1;
    checks++;
    if ({o_v, o_s, lk, ph, sp, o_i, o_q} !== '0) begin
      errs++; $display("FAIL async_clear got v=%b lk=%b ph=%0d sp=%0d i=%h", o_v, lk, ph, sp, o_i);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1'b1, 4'b0000, 0);
    checks++; if ({o_v, lk} !== 2'b00) begin errs++; $display("FAIL post_reset1 got=%b exp=00", {o_v, lk}); end
    step(1'b1, 4'b0000, 1);
    checks++; if ({o_v, o_i} !== {1'b1, wd(0)}) begin errs++; $display("FAIL post_reset2 got v=%b i=%h exp v=1 i=%h", o_v, o_i, wd(0)); end
  endtask

  task automatic test_saturate();
    do_reset();
    stream(40, 8, 4'b0001);
    checks++; if ({lk4, sp4} !== {1'b1, 4'd8}) begin errs++; $display("FAIL sat_lock got lk=%b sp=%0d exp lk=1 sp=8", lk4, sp4); end
    for (int w = 40; w <= 53; w++) step(1'b1, 4'b0000, w);
    checks++; if (lk4 !== 1'b1) begin errs++; $display("FAIL sat_before got=%b exp=1", lk4); end
    step(1'b1, 4'b0000, 54);
    checks++; if (lk4 !== 1'b0) begin errs++; $display("FAIL sat_unlock got=%b exp=0", lk4); end
    checks++; if (ec4 !== E1) begin errs++; $display("FAIL sat_err got=%0d exp=%0d", ec4, E1); end
    for (int w = 55; w <= 60; w++) step(1'b1, 4'b0000, w);
    checks++; if ({lk4, sp4, ec4} !== {1'b0, 4'd8, E1}) begin errs++; $display("FAIL sat_hold got lk=%b sp=%0d ec=%0d exp lk=0 sp=8 ec=%0d", lk4, sp4, ec4, E1); end
  endtask

  initial begin
    test_reset();
    test_lock_phase0();
    test_period_change();
    test_phases();
    test_valid_toggle();
    test_reset_mid();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
